// File: rtl/i2c_phase_clock_unit.sv
// I2C bit-clock generator: divides clk into four quarter-phases per SCL period,
// drives the SCL pull-down and supports slave clock stretching with a timeout.
module i2c_phase_clock_unit #(
  parameter int COUNT_WIDTH   = 16,
  parameter int STRETCH_LIMIT = 100000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [COUNT_WIDTH-1:0] clocksPerQuarter,
  input  logic                   stretchEnable,
  input  logic                   sclIn,
  output logic                   sclOut,
  output logic [1:0]             phase,
  output logic                   quarterTick,
  output logic                   riseTick,
  output logic                   sampleTick,
  output logic                   cycleDone,
  output logic                   stretching,
  output logic                   stretchTimeout
);

  localparam int STRETCH_WIDTH = $clog2(STRETCH_LIMIT + 1);
  localparam logic [STRETCH_WIDTH-1:0] STRETCH_MAX  = STRETCH_WIDTH'(STRETCH_LIMIT);
  localparam logic [STRETCH_WIDTH-1:0] STRETCH_LAST = STRETCH_WIDTH'(STRETCH_LIMIT - 1);
  localparam logic [STRETCH_WIDTH-1:0] STRETCH_ONE  = STRETCH_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0]   COUNT_ONE    = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    PH_LOW_FIRST   = 2'd0,
    PH_LOW_SECOND  = 2'd1,
    PH_HIGH_FIRST  = 2'd2,
    PH_HIGH_SECOND = 2'd3
  } phase_e;

  phase_e                   phaseQ, phaseD;
  logic [COUNT_WIDTH-1:0]   counterQ, counterD;
  logic [STRETCH_WIDTH-1:0] stretchCountQ, stretchCountD;
  logic                     stretchTimeoutQ, stretchTimeoutD;
  logic                     sclMetaQ, sclSyncQ;
  logic                     stretchActive;
  logic                     tickActive;

  // The raw pin is asynchronous; two flops before it may influence the divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclMetaQ <= 1'b1;
      sclSyncQ <= 1'b1;
    end else begin
      sclMetaQ <= sclIn;
      sclSyncQ <= sclMetaQ;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phaseQ          <= PH_LOW_FIRST;
      counterQ        <= COUNT_ONE;
      stretchCountQ   <= '0;
      stretchTimeoutQ <= 1'b0;
    end else begin
      phaseQ          <= phaseD;
      counterQ        <= counterD;
      stretchCountQ   <= stretchCountD;
      stretchTimeoutQ <= stretchTimeoutD;
    end
  end

  // Reset forces the idle output levels even while enable is still held high.
  assign stretchActive = ~reset & enable & stretchEnable &
                         (phaseQ == PH_HIGH_FIRST) & ~sclSyncQ;
  assign tickActive    = ~reset & enable & ~stretchActive &
                         (counterQ >= clocksPerQuarter);

  always_comb begin
    phaseD          = phaseQ;
    counterD        = counterQ;
    stretchCountD   = stretchCountQ;
    stretchTimeoutD = stretchTimeoutQ;
    if (!enable) begin
      phaseD          = PH_LOW_FIRST;
      counterD        = COUNT_ONE;
      stretchCountD   = '0;
      stretchTimeoutD = 1'b0;
    end else if (stretchActive) begin
      counterD = COUNT_ONE;
      if (stretchCountQ != STRETCH_MAX) begin
        stretchCountD = stretchCountQ + STRETCH_ONE;
      end
      if (stretchCountQ == STRETCH_LAST) begin
        stretchTimeoutD = 1'b1;
      end
    end else begin
      stretchCountD = '0;
      if (tickActive) begin
        counterD = COUNT_ONE;
        phaseD   = phase_e'(phaseQ + 2'd1);
      end else begin
        counterD = counterQ + COUNT_ONE;
      end
    end
  end

  assign sclOut         = reset | ~enable | phaseQ[1];
  assign phase          = phaseQ;
  assign quarterTick    = tickActive;
  assign riseTick       = tickActive & (phaseQ == PH_LOW_SECOND);
  assign sampleTick     = tickActive & (phaseQ == PH_HIGH_FIRST);
  assign cycleDone      = tickActive & (phaseQ == PH_HIGH_SECOND);
  assign stretching     = stretchActive;
  assign stretchTimeout = stretchTimeoutQ;

endmodule

// File: tb/tb_i2c_phase_clock_unit.sv
// Bench for i2c_phase_clock_unit: randomized bit-clock segments checked by a
// scoreboard built from quarter-length arithmetic, plus directed corner cases.
module tb_i2c_phase_clock_unit;

  localparam int CW    = 16;
  localparam int LIMIT = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          stretchEnable = 1'b0;
  logic          sclInDrv = 1'b1;
  logic          loopback = 1'b0;
  logic [CW-1:0] clocksPerQuarter = '0;
  logic          sclIn;
  logic          sclOut;
  logic [1:0]    phase;
  logic          quarterTick, riseTick, sampleTick, cycleDone;
  logic          stretching, stretchTimeout;

  typedef struct { int cyc; int ph; } tick_t;
  typedef struct { int cyc; logic scl; logic str; } level_t;

  tick_t  tickQ[$];
  level_t levelQ[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  bit     sbOn = 1'b0;

  assign sclIn = loopback ? sclOut : sclInDrv;

  i2c_phase_clock_unit #(
    .COUNT_WIDTH(CW),
    .STRETCH_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .clocksPerQuarter(clocksPerQuarter),
    .stretchEnable(stretchEnable),
    .sclIn(sclIn),
    .sclOut(sclOut),
    .phase(phase),
    .quarterTick(quarterTick),
    .riseTick(riseTick),
    .sampleTick(sampleTick),
    .cycleDone(cycleDone),
    .stretching(stretching),
    .stretchTimeout(stretchTimeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Monitor: pops expected tick events and per-cycle levels as the DUT presents them.
  always @(negedge clk) begin
    tick_t  t;
    level_t l;
    if (sbOn) begin
      while (tickQ.size() > 0 && tickQ[0].cyc < cyc) begin
        t = tickQ.pop_front();
        checkOutput("tickMissed", cyc, t.cyc);
      end
      if (quarterTick) begin
        if (tickQ.size() == 0) begin
          checkOutput("tickUnexpected", quarterTick, 0);
        end else begin
          t = tickQ.pop_front();
          checkOutput("tickCycle", cyc, t.cyc);
          checkOutput("tickPhase", phase, t.ph);
          checkOutput("riseTick", riseTick, t.ph == 1);
          checkOutput("sampleTick", sampleTick, t.ph == 2);
          checkOutput("cycleDone", cycleDone, t.ph == 3);
        end
      end
      while (levelQ.size() > 0 && levelQ[0].cyc <= cyc) begin
        l = levelQ.pop_front();
        if (l.cyc == cyc) begin
          checkOutput("sclOut", sclOut, l.scl);
          checkOutput("stretching", stretching, l.str);
          checkOutput("stretchTimeoutLow", stretchTimeout, 0);
        end else begin
          checkOutput("levelMissed", cyc, l.cyc);
        end
      end
    end
    if (!quarterTick) begin
      checkOutput("phaseTicksIdle", {riseTick, sampleTick, cycleDone}, 0);
    end
  end

  // One enabled run of whole SCL periods followed by an idle gap; called just after a posedge.
  task automatic applyStimulus(input int cpq, input bit s, input int periods, input int idle);
    int len, extra, per, c0, n, base;
    len   = (cpq == 0) ? 1 : cpq;
    extra = s ? 2 : 0;
    per   = 4 * len + extra;
    n     = periods * per;
    clocksPerQuarter = CW'(cpq);
    stretchEnable    = s;
    loopback         = s ? 1'b1 : 1'($urandom_range(0, 1));
    enable           = 1'b1;
    c0 = cyc;
    for (int p = 0; p < periods; p++) begin
      base = c0 + p * per;
      tickQ.push_back('{base + len - 1, 0});
      tickQ.push_back('{base + 2 * len - 1, 1});
      tickQ.push_back('{base + 3 * len + extra - 1, 2});
      tickQ.push_back('{base + 4 * len + extra - 1, 3});
      for (int i = 0; i < per; i++) begin
        levelQ.push_back('{base + i, i >= 2 * len, s && (i >= 2 * len) && (i < 2 * len + 2)});
      end
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (!loopback) sclInDrv = 1'($urandom_range(0, 1));
    end
    enable = 1'b0;
    for (int j = 0; j < idle; j++) levelQ.push_back('{c0 + n + j, 1'b1, 1'b0});
    for (int j = 0; j < idle; j++) begin
      @(posedge clk); #1;
      sclInDrv = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit found;
    #1 reset = 1'b1;
    #1;
    checkOutput("resetPhase", phase, 0);
    checkOutput("resetSclOut", sclOut, 1);
    checkOutput("resetTick", quarterTick, 0);
    checkOutput("resetStretching", stretching, 0);
    checkOutput("resetTimeout", stretchTimeout, 0);
    #20;
    @(negedge clk) reset = 1'b0;
    sbOn = 1'b1;

    // Idle: nothing moves regardless of the SCL pin.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput("idleSclOut", sclOut, 1);
      checkOutput("idlePhase", phase, 0);
      checkOutput("idleStretching", stretching, 0);
      sclInDrv = 1'($urandom_range(0, 1));
    end

    @(posedge clk); #1;
    applyStimulus(3, 1'b0, 2, 3);
    applyStimulus(0, 1'b0, 2, 3);
    applyStimulus(1, 1'b0, 2, 3);
    applyStimulus(3, 1'b1, 2, 3);
    for (int r = 0; r < 30; r++) begin
      applyStimulus($urandom_range(0, 6), 1'($urandom_range(0, 1)),
                    $urandom_range(1, 3), $urandom_range(2, 5));
    end
    checkOutput("tickQueueDrained", tickQ.size(), 0);
    sbOn = 1'b0;

    // Slave holds SCL low for 20 cycles in phase 2.
    clocksPerQuarter = CW'(3);
    stretchEnable    = 1'b1;
    loopback         = 1'b0;
    sclInDrv         = 1'b1;
    enable           = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (phase == 2'd2) found = 1'b1;
    end
    checkOutput("reachPhase2", found, 1);
    sclInDrv = 1'b0;
    for (int k = 0; k <= 25; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput("holdStretching", stretching, (k >= 2) && (k <= 21));
      checkOutput("holdTimeout", stretchTimeout, k >= 12);
      checkOutput("holdPhase", phase, (k <= 24) ? 2 : 3);
      checkOutput("holdSampleTick", sampleTick, k == 24);
      checkOutput("holdSclOut", sclOut, 1);
      if (k == 20) sclInDrv = 1'b1;
    end
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk); #1 enable = 1'b1;
    @(negedge clk);
    checkOutput("timeoutCleared", stretchTimeout, 0);
    checkOutput("restartPhase", phase, 0);
    checkOutput("restartSclOut", sclOut, 0);

    // Lower the quarter length below the running count.
    @(posedge clk); #1;
    enable = 1'b0;
    stretchEnable = 1'b0;
    clocksPerQuarter = CW'(10);
    @(posedge clk); #1 enable = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("slowNoTick", quarterTick, 0);
    @(posedge clk); #1 clocksPerQuarter = CW'(2);
    @(negedge clk);
    checkOutput("loweredTick", quarterTick, 1);
    checkOutput("loweredPhase", phase, 0);
    @(negedge clk);
    checkOutput("afterLowerPhase", phase, 1);
    checkOutput("afterLowerTick", quarterTick, 0);
    @(negedge clk);
    checkOutput("afterLowerRise", riseTick, 1);
    @(negedge clk);
    checkOutput("preResetPhase", phase, 2);
    checkOutput("preResetSclOut", sclOut, 1);
    reset = 1'b1;
    #1;
    checkOutput("asyncResetPhase", phase, 0);
    checkOutput("asyncResetSclOut", sclOut, 1);
    checkOutput("asyncResetTick", quarterTick, 0);
    @(posedge clk); #1;
    checkOutput("heldResetPhase", phase, 0);
    checkOutput("heldResetSclOut", sclOut, 1);
    reset  = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
